// File: rtl/fetch_queue.sv
// Instruction fetch front end: reads 32-bit words, splits them into big-endian
// 16-bit parcels and queues them with their PCs for the decoder.
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    QDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_data,
  input  logic                  d_ready,
  output logic                  opready,
  output logic [15:0]           op,
  output logic [DATA_WIDTH-1:0] pc_f,
  output logic [DATA_WIDTH-1:0] pcnext
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] HALF_MASK = ~DATA_WIDTH'(1);

  logic [15:0]           q_op [QDEPTH];
  logic [DATA_WIDTH-1:0] q_pc [QDEPTH];

  logic [PW-1:0]         head_reg, tail_reg, tail_second;
  logic [CW-1:0]         count_reg, count_next, push_cnt;
  logic [DATA_WIDTH-1:0] fpc_reg, addr_reg;
  logic                  busy_reg, drop_reg;
  logic [15:0]           op_hold_reg;
  logic [DATA_WIDTH-1:0] pc_hold_reg;

  logic                  empty, issue, ack, push_en, push_two, pop;
  logic [15:0]           first_op;
  logic [DATA_WIDTH-1:0] first_pc, second_pc;

  assign empty    = (count_reg == '0);
  // A redirect never issues with the stale fetch PC; the new PC issues next cycle.
  assign issue    = !busy_reg && !redirect && (count_reg <= CW'(QDEPTH - 2));
  assign mem_req  = !rst && (busy_reg || issue);
  assign mem_addr = busy_reg ? addr_reg : (fpc_reg & WORD_MASK);
  assign ack      = mem_req && mem_ack;
  assign push_en  = ack && !drop_reg && !redirect;
  assign push_two = !fpc_reg[1];

  assign opready  = !empty && d_ready && !redirect;
  assign pop      = opready;

  assign push_cnt    = push_en ? (push_two ? CW'(2) : CW'(1)) : '0;
  assign count_next  = count_reg + push_cnt - CW'(pop);
  assign tail_second = tail_reg + PW'(1);

  assign second_pc = mem_addr + DATA_WIDTH'(2);
  assign first_op  = push_two ? mem_data[31:16] : mem_data[15:0];
  assign first_pc  = push_two ? mem_addr : second_pc;

  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
      logic [15:0]           op_reg;
      logic [DATA_WIDTH-1:0] pc_reg;
      logic                  we_first, we_second;

      assign we_first  = push_en && (tail_reg == PW'(gi));
      assign we_second = push_en && push_two && (tail_second == PW'(gi));

      always_ff @(posedge clk) begin
        if (we_first) begin
          op_reg <= first_op;
          pc_reg <= first_pc;
        end else if (we_second) begin
          op_reg <= mem_data[15:0];
          pc_reg <= second_pc;
        end
      end

      assign q_op[gi] = op_reg;
      assign q_pc[gi] = pc_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      fpc_reg     <= RESET_PC;
      addr_reg    <= RESET_PC & WORD_MASK;
      busy_reg    <= 1'b0;
      drop_reg    <= 1'b0;
      op_hold_reg <= '0;
      pc_hold_reg <= RESET_PC;
    end else begin
      busy_reg <= (busy_reg || issue) && !mem_ack;
      if (!busy_reg) begin
        addr_reg <= mem_addr;
      end

      if (ack) begin
        drop_reg <= 1'b0;
      end else if (redirect && busy_reg) begin
        drop_reg <= 1'b1;
      end

      // Both odd and even starts resume at the word after the one just fetched.
      if (redirect) begin
        fpc_reg <= redirect_pc & HALF_MASK;
      end else if (push_en) begin
        fpc_reg <= mem_addr + DATA_WIDTH'(4);
      end

      if (redirect) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        head_reg  <= head_reg + PW'(pop);
        tail_reg  <= tail_reg + PW'(push_cnt);
        count_reg <= count_next;
      end

      if (!empty) begin
        op_hold_reg <= q_op[head_reg];
        pc_hold_reg <= q_pc[head_reg];
      end
    end
  end

  assign op     = empty ? op_hold_reg : q_op[head_reg];
  assign pc_f   = empty ? pc_hold_reg : q_pc[head_reg];
  assign pcnext = pc_f + DATA_WIDTH'(2);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a main instance at RESET_PC 0x100 and a second
// instance at RESET_PC 0xFFFFFFFC for the address wrap.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, redirect, mem_req, mem_ack, d_ready, opready;
  logic [31:0] redirect_pc, mem_addr, mem_data, pc_f, pcnext;
  logic [15:0] op;

  logic        rst_w, redirect_w, mem_req_w, mem_ack_w, opready_w;
  logic [31:0] redirect_pc_w, mem_addr_w, mem_data_w, pc_f_w, pcnext_w;
  logic [15:0] op_w;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int req_age = 0;
  logic [31:0] req_addr;
  logic [15:0] log_op[$];
  logic [31:0] log_pc[$];

  always #5 clk = ~clk;

  fetch_queue #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0100), .QDEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .d_ready(d_ready), .opready(opready), .op(op), .pc_f(pc_f), .pcnext(pcnext)
  );

  fetch_queue #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .QDEPTH(4)) u_wrap (
    .clk(clk), .rst(rst_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w), .mem_data(mem_data_w),
    .d_ready(d_ready), .opready(opready_w), .op(op_w), .pc_f(pc_f_w), .pcnext(pcnext_w)
  );

  // Words 0x100/0x104 carry the reference pattern; elsewhere each parcel equals
  // the low 16 bits of its own address, so any misplaced parcel is visible.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h30A1_0005;
    if (a == 32'h0000_0104) return 32'h4123_F000;
    return {a[15:0], a[15:0] + 16'd2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, answer memory requests,
  // log presented parcels. Returns mid-cycle so the caller can check outputs.
  task automatic run_cycle(input logic r, input logic rw, input logic rd,
                           input logic [31:0] rpc, input logic dr);
    @(negedge clk);
    rst = r; rst_w = rw; redirect = rd; redirect_pc = rpc; d_ready = dr;
    mem_ack = 1'b0; mem_ack_w = 1'b0;
    #1;
    if (mem_req) begin
      if (req_age == 0) req_addr = mem_addr;
      else chk("addr_stable", mem_addr, req_addr);
      if (req_age >= lat) begin
        mem_ack = 1'b1;
        mem_data = mem_word(mem_addr);
        req_age = 0;
      end else begin
        req_age++;
      end
    end else begin
      req_age = 0;
    end
    mem_ack_w = mem_req_w;
    mem_data_w = mem_word(mem_addr_w);
    if (opready) begin
      log_op.push_back(op);
      log_pc.push_back(pc_f);
      chk("pcnext", pcnext, pc_f + 32'd2);
    end
    if (opready_w) chk("pcnext_w", pcnext_w, pc_f_w + 32'd2);
    $display("cyc t=%0t req=%b addr=%h ack=%b opready=%b op=%h pc=%h",
             $time, mem_req, mem_addr, mem_ack, opready, op, pc_f);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h100);
    chk({tag, "_opready"}, opready, 0);
    chk({tag, "_op"}, op, 0);
    chk({tag, "_pc_f"}, pc_f, 32'h100);
    chk({tag, "_pcnext"}, pcnext, 32'h102);
  endtask

  initial begin
    int nreq;
    int nop;
    logic [31:0] exp_op;
    rst = 1; rst_w = 1; redirect = 0; redirect_pc = 0; d_ready = 1;
    mem_ack = 0; mem_data = 0; mem_ack_w = 0; mem_data_w = 0;
    redirect_w = 0; redirect_pc_w = 0;

    // Reset
    run_cycle(1, 1, 0, 0, 1);
    run_cycle(1, 1, 0, 0, 1);
    chk_reset_values("rst");
    chk("rst_w_mem_addr", mem_addr_w, 32'hFFFF_FFFC);
    chk("rst_w_pc_f", pc_f_w, 32'hFFFF_FFFC);
    chk("rst_w_pcnext", pcnext_w, 32'hFFFF_FFFE);

    // Zero-wait streaming, d_ready high
    run_cycle(0, 1, 0, 0, 1);
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 32'h100);
    for (int k = 1; k < 7; k++) run_cycle(0, 1, 0, 0, 1);

    // Backpressure: one more fetch fills the queue, then nothing
    run_cycle(0, 1, 0, 0, 0);
    chk("bp_last_req", mem_req, 1);
    chk("bp_last_addr", mem_addr, 32'h110);
    nreq = 0; nop = 0;
    for (int k = 0; k < 19; k++) begin
      run_cycle(0, 1, 0, 0, 0);
      if (mem_req) nreq++;
      if (opready) nop++;
    end
    chk("bp_req_count", nreq, 0);
    chk("bp_opready_count", nop, 0);
    for (int k = 0; k < 4; k++) run_cycle(0, 1, 0, 0, 1);
    chk("stream_len", log_pc.size(), 10);
    for (int i = 0; i < 10 && i < log_pc.size(); i++) begin
      case (i)
        0: exp_op = 32'h30A1;
        1: exp_op = 32'h0005;
        2: exp_op = 32'h4123;
        3: exp_op = 32'hF000;
        default: exp_op = (32'h100 + 32'(2 * i)) & 32'hFFFF;
      endcase
      chk($sformatf("stream_pc%0d", i), log_pc[i], 32'h100 + 32'(2 * i));
      chk($sformatf("stream_op%0d", i), {16'h0, log_op[i]}, exp_op);
    end

    // Odd-halfword redirect while idle
    run_cycle(0, 1, 1, 32'h206, 1);
    chk("rd206_opready", opready, 0);
    chk("rd206_mem_req", mem_req, 0);
    run_cycle(0, 1, 0, 0, 1);
    chk("rd206_empty", opready, 0);
    chk("rd206_req", mem_req, 1);
    chk("rd206_addr", mem_addr, 32'h204);
    run_cycle(0, 1, 0, 0, 1);
    chk("rd206_op_valid", opready, 1);
    chk("rd206_op", op, 16'h0206);
    chk("rd206_pc", pc_f, 32'h206);
    chk("rd206_pcnext", pcnext, 32'h208);
    chk("rd206_next_addr", mem_addr, 32'h208);
    run_cycle(0, 1, 0, 0, 1);
    chk("rd206_op2", op, 16'h0208);
    chk("rd206_pc2", pc_f, 32'h208);

    // Redirect during an outstanding request (ack on third request cycle)
    lat = 2;
    run_cycle(0, 1, 1, 32'h120, 1);
    chk("drop_rd_opready", opready, 0);
    run_cycle(0, 1, 0, 0, 1);
    chk("drop_req120", mem_req, 1);
    chk("drop_addr120", mem_addr, 32'h120);
    run_cycle(0, 1, 1, 32'h401, 1);   // bit 0 of redirect_pc is ignored
    chk("drop_rd2_opready", opready, 0);
    chk("drop_inflight_addr", mem_addr, 32'h120);
    run_cycle(0, 1, 0, 0, 1);
    chk("drop_ack_req", mem_req, 1);
    chk("drop_ack_addr", mem_addr, 32'h120);
    chk("drop_ack_opready", opready, 0);
    run_cycle(0, 1, 0, 0, 1);
    chk("drop_new_req", mem_req, 1);
    chk("drop_new_addr", mem_addr, 32'h400);
    nop = opready ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      run_cycle(0, 1, 0, 0, 1);
      if (opready) nop++;
    end
    chk("drop_no_parcel", nop, 0);
    run_cycle(0, 1, 0, 0, 1);
    chk("drop_op", op, 16'h0400);
    chk("drop_pc", pc_f, 32'h400);

    // Redirect coincident with ack and a pending pop
    run_cycle(0, 1, 0, 0, 0);
    run_cycle(0, 1, 1, 32'h500, 1);
    chk("coinc_ack", mem_ack, 1);
    chk("coinc_opready", opready, 0);
    run_cycle(0, 1, 0, 0, 1);
    chk("coinc_empty", opready, 0);
    chk("coinc_hold_op", op, 16'h0402);
    chk("coinc_hold_pc", pc_f, 32'h402);
    chk("coinc_req", mem_req, 1);
    chk("coinc_addr", mem_addr, 32'h500);
    run_cycle(0, 1, 0, 0, 1);
    run_cycle(0, 1, 0, 0, 1);
    run_cycle(0, 1, 0, 0, 1);
    chk("coinc_op", op, 16'h0500);
    chk("coinc_pc", pc_f, 32'h500);
    chk("mid_req", mem_req, 1);
    chk("mid_addr", mem_addr, 32'h504);

    // Reset while a request is outstanding
    run_cycle(1, 1, 0, 0, 1);
    run_cycle(1, 1, 0, 0, 1);
    chk_reset_values("midrst");
    run_cycle(0, 1, 0, 0, 1);
    chk("post_rst_req", mem_req, 1);
    chk("post_rst_addr", mem_addr, 32'h100);

    // Address wrap on the second instance
    run_cycle(0, 0, 0, 0, 1);
    chk("wrap_req", mem_req_w, 1);
    chk("wrap_addr0", mem_addr_w, 32'hFFFF_FFFC);
    run_cycle(0, 0, 0, 0, 1);
    chk("wrap_addr1", mem_addr_w, 32'h0);
    chk("wrap_opready", opready_w, 1);
    chk("wrap_op0", op_w, 16'hFFFC);
    chk("wrap_pc0", pc_f_w, 32'hFFFF_FFFC);
    chk("wrap_pcnext0", pcnext_w, 32'hFFFF_FFFE);
    run_cycle(0, 0, 0, 0, 1);
    chk("wrap_op1", op_w, 16'hFFFE);
    chk("wrap_pc1", pc_f_w, 32'hFFFF_FFFE);
    chk("wrap_pcnext1", pcnext_w, 32'h0);
    run_cycle(0, 0, 0, 0, 1);
    chk("wrap_op2", op_w, 16'h0000);
    chk("wrap_pc2", pc_f_w, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
